// File: rtl/sub_share_arb.sv
// Round-robin arbiter sharing one downstream SUB unit between NREQ requesters.
// Grants are exclusive and registered; a hold-time limit revokes long owners when others wait.
module sub_share_arb #(
  parameter int unsigned NREQ     = 4,
  parameter int unsigned MAX_HOLD = 8
) (
  input  logic            i_clk,
  input  logic            i_rst_n,
  input  logic [NREQ-1:0] i_req,
  input  logic [NREQ-1:0] i_in,
  output logic [NREQ-1:0] o_gnt,
  output logic [2:0]      o_gnt_id,
  output logic            o_busy,
  output logic            o_sub_in,
  output logic            o_timeout
);

  localparam int unsigned IW = $clog2(NREQ);
  localparam int unsigned CW = $clog2(MAX_HOLD);
  localparam logic [CW-1:0] CntMax = CW'(MAX_HOLD - 1);
  localparam logic [IW-1:0] PtrRst = IW'(NREQ - 1);

  typedef enum logic [1:0] {StIdle, StGrant, StGap} state_e;

  state_e          r_state,   w_state_d;
  logic [NREQ-1:0] r_gnt,     w_gnt_d;
  logic [2:0]      r_gnt_id,  w_gnt_id_d;
  logic [IW-1:0]   r_ptr,     w_ptr_d;
  logic [CW-1:0]   r_cnt,     w_cnt_d;
  logic            r_timeout, w_timeout_d;

  logic            w_win_valid;
  logic [IW-1:0]   w_win_id;
  logic [NREQ-1:0] w_win_oh;
  logic            w_owner_req;
  logic            w_others_req;

  // Search starts one past the last owner so the previous winner is considered last.
  always_comb begin
    int unsigned idx;
    w_win_valid = 1'b0;
    w_win_id    = '0;
    w_win_oh    = '0;
    idx         = 0;
    for (int unsigned i = 1; i <= NREQ; i++) begin
      idx = (int'(r_ptr) + i) % NREQ;
      if (!w_win_valid && i_req[IW'(idx)]) begin
        w_win_valid = 1'b1;
        w_win_id    = IW'(idx);
        w_win_oh    = NREQ'(1) << idx;
      end
    end
  end

  assign w_owner_req  = |(i_req & r_gnt);
  assign w_others_req = |(i_req & ~r_gnt);

  always_comb begin
    w_state_d   = r_state;
    w_gnt_d     = r_gnt;
    w_gnt_id_d  = r_gnt_id;
    w_ptr_d     = r_ptr;
    w_cnt_d     = r_cnt;
    w_timeout_d = 1'b0;
    unique case (r_state)
      StIdle, StGap: begin
        if (w_win_valid) begin
          w_state_d  = StGrant;
          w_gnt_d    = w_win_oh;
          w_gnt_id_d = 3'(w_win_id);
          w_ptr_d    = w_win_id;
          w_cnt_d    = '0;
        end else begin
          w_state_d  = StIdle;
          w_gnt_d    = '0;
          w_gnt_id_d = '0;
        end
      end
      StGrant: begin
        if (!w_owner_req) begin
          // Release wins over a coincident timeout, so no pulse here.
          w_state_d  = StGap;
          w_gnt_d    = '0;
          w_gnt_id_d = '0;
        end else if (r_cnt == CntMax && w_others_req) begin
          w_state_d   = StGap;
          w_gnt_d     = '0;
          w_gnt_id_d  = '0;
          w_timeout_d = 1'b1;
        end else if (r_cnt != CntMax) begin
          w_cnt_d = r_cnt + CW'(1);
        end
      end
      default: begin
        w_state_d  = StIdle;
        w_gnt_d    = '0;
        w_gnt_id_d = '0;
      end
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state   <= StIdle;
      r_gnt     <= '0;
      r_gnt_id  <= '0;
      r_ptr     <= PtrRst;
      r_cnt     <= '0;
      r_timeout <= 1'b0;
    end else begin
      r_state   <= w_state_d;
      r_gnt     <= w_gnt_d;
      r_gnt_id  <= w_gnt_id_d;
      r_ptr     <= w_ptr_d;
      r_cnt     <= w_cnt_d;
      r_timeout <= w_timeout_d;
    end
  end

  assign o_gnt     = r_gnt;
  assign o_gnt_id  = r_gnt_id;
  assign o_busy    = (r_state == StGrant);
  assign o_timeout = r_timeout;
  // r_gnt is zero outside GRANT, so this is IN[GNT_ID] when busy and 0 otherwise.
  assign o_sub_in  = |(i_in & r_gnt);

endmodule

// File: tb/tb_sub_share_arb.sv
// Scenario-driven bench for sub_share_arb: expected outputs are queued per cycle as
// stimulus is applied and popped after the clock edge.
module tb_sub_share_arb;

  localparam int NREQ     = 4;
  localparam int MAX_HOLD = 8;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [3:0] req = '0;
  logic [3:0] din = '0;
  logic [3:0] gnt;
  logic [2:0] gnt_id;
  logic       busy;
  logic       sub_in;
  logic       timeout;

  typedef struct {
    string      name;
    logic [9:0] exp;
  } sb_t;

  sb_t sb[$];
  int  n_tests = 0;
  int  n_fail  = 0;

  sub_share_arb #(
    .NREQ     (NREQ),
    .MAX_HOLD (MAX_HOLD)
  ) dut (
    .i_clk     (clk),
    .i_rst_n   (rst_n),
    .i_req     (req),
    .i_in      (din),
    .o_gnt     (gnt),
    .o_gnt_id  (gnt_id),
    .o_busy    (busy),
    .o_sub_in  (sub_in),
    .o_timeout (timeout)
  );

  always #5 clk = ~clk;

  // Expected {gnt, gnt_id, busy, timeout, sub_in}; owner -1 = dead cycle, -2 = dead cycle + timeout.
  function automatic logic [9:0] ex(int owner);
    if (owner == -1) return 10'b0;
    if (owner == -2) return 10'b0000_000_0_1_0;
    return {4'(1 << owner), 3'(owner), 1'b1, 1'b0, din[owner]};
  endfunction

  task automatic do_reset();
    rst_n = 1'b0;
    req   = '0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    logic [9:0] obs;
    rst_n = 1'b0;
    req   = 4'b1111;
    din   = 4'b1111;
    #1;
    obs = {gnt, gnt_id, busy, timeout, sub_in};
    n_tests++;
    if (obs !== 10'b0) begin
      n_fail++;
      $display("FAIL reset_async: got %b want %b", obs, 10'b0);
    end
    @(posedge clk);
    #1;
    obs = {gnt, gnt_id, busy, timeout, sub_in};
    n_tests++;
    if (obs !== 10'b0) begin
      n_fail++;
      $display("FAIL reset_held_edge: got %b want %b", obs, 10'b0);
    end
    req   = '0;
    rst_n = 1'b1;
  endtask

  task automatic test_single_grant();
    logic [3:0] rq[$];
    int         ow[$];
    logic [9:0] obs;
    sb_t        e;
    do_reset();
    rq = '{4'b0100, 4'b0100, 4'b0100, 4'b0000, 4'b0000};
    ow = '{2, 2, 2, -1, -1};
    for (int c = 0; c < rq.size(); c++) begin
      req = rq[c];
      din = 4'($urandom);
      sb.push_back('{$sformatf("single_c%0d", c), ex(ow[c])});
      @(posedge clk);
      #1;
      e   = sb.pop_front();
      obs = {gnt, gnt_id, busy, timeout, sub_in};
      n_tests++;
      if (obs !== e.exp) begin
        n_fail++;
        $display("FAIL %s: got %b want %b", e.name, obs, e.exp);
      end
    end
  endtask

  task automatic test_round_robin();
    logic [3:0] rq[$];
    int         ow[$];
    logic [9:0] obs;
    sb_t        e;
    do_reset();
    for (int k = 0; k < 5; k++) begin
      rq.push_back(4'b1111); ow.push_back(k % 4);
      rq.push_back(4'b1111); ow.push_back(k % 4);
      if (k < 4) begin
        rq.push_back(4'b1111 & ~4'(1 << (k % 4)));
        ow.push_back(-1);
      end
    end
    for (int c = 0; c < rq.size(); c++) begin
      req = rq[c];
      din = 4'($urandom);
      sb.push_back('{$sformatf("rr_c%0d", c), ex(ow[c])});
      @(posedge clk);
      #1;
      e   = sb.pop_front();
      obs = {gnt, gnt_id, busy, timeout, sub_in};
      n_tests++;
      if (obs !== e.exp) begin
        n_fail++;
        $display("FAIL %s: got %b want %b", e.name, obs, e.exp);
      end
    end
  endtask

  task automatic test_hold_limit();
    logic [3:0] rq[$];
    int         ow[$];
    logic [9:0] obs;
    sb_t        e;
    do_reset();
    for (int c = 0; c < MAX_HOLD; c++) begin
      rq.push_back(c < 2 ? 4'b0010 : 4'b1010);
      ow.push_back(1);
    end
    rq.push_back(4'b1010); ow.push_back(-2);
    rq.push_back(4'b1010); ow.push_back(3);
    rq.push_back(4'b0000); ow.push_back(-1);
    rq.push_back(4'b0000); ow.push_back(-1);
    for (int c = 0; c < rq.size(); c++) begin
      req = rq[c];
      din = 4'($urandom);
      sb.push_back('{$sformatf("hold_c%0d", c), ex(ow[c])});
      @(posedge clk);
      #1;
      e   = sb.pop_front();
      obs = {gnt, gnt_id, busy, timeout, sub_in};
      n_tests++;
      if (obs !== e.exp) begin
        n_fail++;
        $display("FAIL %s: got %b want %b", e.name, obs, e.exp);
      end
    end
  endtask

  task automatic test_lone();
    logic [3:0] rq[$];
    int         ow[$];
    logic [9:0] obs;
    sb_t        e;
    do_reset();
    for (int c = 0; c < 20; c++) begin
      rq.push_back(4'b0001);
      ow.push_back(0);
    end
    rq.push_back(4'b0000); ow.push_back(-1);
    rq.push_back(4'b0000); ow.push_back(-1);
    for (int c = 0; c < rq.size(); c++) begin
      req = rq[c];
      din = 4'($urandom);
      sb.push_back('{$sformatf("lone_c%0d", c), ex(ow[c])});
      @(posedge clk);
      #1;
      e   = sb.pop_front();
      obs = {gnt, gnt_id, busy, timeout, sub_in};
      n_tests++;
      if (obs !== e.exp) begin
        n_fail++;
        $display("FAIL %s: got %b want %b", e.name, obs, e.exp);
      end
    end
  endtask

  task automatic test_collision();
    logic [3:0] rq[$];
    int         ow[$];
    logic [9:0] obs;
    sb_t        e;
    do_reset();
    for (int c = 0; c < MAX_HOLD; c++) begin
      rq.push_back(4'b0101);
      ow.push_back(0);
    end
    // Owner drops exactly when the hold limit would fire.
    rq.push_back(4'b0100); ow.push_back(-1);
    rq.push_back(4'b0100); ow.push_back(2);
    rq.push_back(4'b0000); ow.push_back(-1);
    rq.push_back(4'b0000); ow.push_back(-1);
    for (int c = 0; c < rq.size(); c++) begin
      req = rq[c];
      din = 4'($urandom);
      sb.push_back('{$sformatf("collide_c%0d", c), ex(ow[c])});
      @(posedge clk);
      #1;
      e   = sb.pop_front();
      obs = {gnt, gnt_id, busy, timeout, sub_in};
      n_tests++;
      if (obs !== e.exp) begin
        n_fail++;
        $display("FAIL %s: got %b want %b", e.name, obs, e.exp);
      end
    end
  endtask

  task automatic test_async_reset();
    logic [9:0] obs;
    sb_t        e;
    do_reset();
    for (int c = 0; c < 2; c++) begin
      req = 4'b0010;
      din = 4'($urandom) | 4'b0010;
      sb.push_back('{$sformatf("arst_grant_c%0d", c), ex(1)});
      @(posedge clk);
      #1;
      e   = sb.pop_front();
      obs = {gnt, gnt_id, busy, timeout, sub_in};
      n_tests++;
      if (obs !== e.exp) begin
        n_fail++;
        $display("FAIL %s: got %b want %b", e.name, obs, e.exp);
      end
    end
    sb.push_back('{"arst_mid_cycle", ex(-1)});
    rst_n = 1'b0;
    #1;
    e   = sb.pop_front();
    obs = {gnt, gnt_id, busy, timeout, sub_in};
    n_tests++;
    if (obs !== e.exp) begin
      n_fail++;
      $display("FAIL %s: got %b want %b", e.name, obs, e.exp);
    end
    req = 4'b1111;
    #2;
    rst_n = 1'b1;
    sb.push_back('{"arst_first_grant", ex(0)});
    @(posedge clk);
    #1;
    e   = sb.pop_front();
    obs = {gnt, gnt_id, busy, timeout, sub_in};
    n_tests++;
    if (obs !== e.exp) begin
      n_fail++;
      $display("FAIL %s: got %b want %b", e.name, obs, e.exp);
    end
    req = '0;
  endtask

  initial begin
    test_reset();
    test_single_grant();
    test_round_robin();
    test_hold_limit();
    test_lone();
    test_collision();
    test_async_reset();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
